// File: rtl/uart_imem_loader.sv
// UART program-image loader: 8N1 receiver plus a length/data framing FSM that emits imem word writes.
// Optional checksum byte after the image when UART_LOADER_CHECKSUM_EN is defined.
module uart_imem_loader #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int IMEM_BYTES  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [31:0] byte_address,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic        loading,
    output logic        done,
    output logic        error
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      MAX_WORDS = 32'(IMEM_BYTES / 4);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {P_LEN, P_DATA, P_CSUM, P_DONE} p_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam p_state_t P_AFTER_DATA = P_CSUM;
`else
    localparam p_state_t P_AFTER_DATA = P_DONE;
`endif

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_valid, rx_ferr;

    p_state_t         p_state_q, p_state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      len_q, len_d, len_full;
    logic [31:0]      word_idx_q, word_idx_d;
    logic [31:0]      byte_address_q, byte_address_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             write_enable_q, write_enable_d;
    logic             loading_q, loading_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign len_full = {shift_q, len_q[23:0]};

    // Bit timing: start bit sampled at its midpoint, then every CLKS_PER_BIT.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_LAST) begin
                cnt_d      = '0;
                bit_idx_d  = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == BIT_LAST) begin
                cnt_d     = '0;
                shift_d   = {rx_sync_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    rx_valid   = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_ferr    = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        p_state_d      = p_state_q;
        byte_cnt_d     = byte_cnt_q;
        len_d          = len_q;
        word_idx_d     = word_idx_q;
        byte_address_d = byte_address_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
        error_d        = error_q;
        done_d         = done_q | (p_state_q == P_DONE);
        loading_d      = loading_q & (p_state_q != P_DONE);
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        if (rx_ferr && p_state_q != P_DONE) error_d = 1'b1;
        case (p_state_q)
            P_LEN: if (rx_valid) begin
                len_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q == 2'd3) begin
                    word_idx_d = '0;
                    if (len_full == '0) begin
                        p_state_d = P_DONE;
                    end else if (len_full > MAX_WORDS) begin
                        error_d   = 1'b1;
                        p_state_d = P_DONE;
                    end else begin
                        p_state_d = P_DATA;
                    end
                end
            end
            P_DATA: begin
                // Leave S_DATA only after the final strobe so it never overlaps another state.
                if (write_enable_q && word_idx_q == len_q) begin
                    p_state_d = P_AFTER_DATA;
                end else if (rx_valid) begin
                    write_data_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ shift_q;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        write_enable_d = 1'b1;
                        byte_address_d = word_idx_q << 2;
                        word_idx_d     = word_idx_q + 1'b1;
                    end
                end
            end
            P_CSUM: begin
`ifdef UART_LOADER_CHECKSUM_EN
                if (rx_valid) begin
                    if (shift_q != csum_q) error_d = 1'b1;
                    p_state_d = P_DONE;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchronizer resets to the idle-high line level so reset never looks like a start bit.
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            p_state_q      <= P_LEN;
            byte_cnt_q     <= '0;
            len_q          <= '0;
            word_idx_q     <= '0;
            byte_address_q <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            loading_q      <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            rx_meta_q      <= uart_rx;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            rx_state_q     <= rx_state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            p_state_q      <= p_state_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            word_idx_q     <= word_idx_d;
            byte_address_q <= byte_address_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
            loading_q      <= loading_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign byte_address = byte_address_q;
    assign write_enable = write_enable_q;
    assign write_data   = write_data_q;
    assign loading      = loading_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected writes are queued by the stimulus and
// popped by an independent write-port monitor; status flags are checked after each scenario.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [31:0] byte_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        loading, done, error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_compared   = 0;
    int  n_mismatched = 0;

    uart_imem_loader #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD_RATE  (250_000),
        .IMEM_BYTES (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .byte_address(byte_address),
        .write_enable(write_enable),
        .write_data  (write_data),
        .loading     (loading),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Write-port monitor: every strobe cycle must match the oldest queued write.
    initial begin
        forever begin
            @(negedge clk);
            if (write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none at %0t",
                             byte_address, write_data, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", byte_address, e.addr);
                    check("write_data", write_data, e.data);
                end
            end
        end
    end

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One 8N1 frame (4 clocks per bit) followed by 8 idle clocks; entered and left on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(c, 1'b1);
`else
        if (c === 8'hxx) $display("unused checksum argument");
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_rst_addr"}, byte_address, 32'h0);
        check({tag, "_rst_we"}, {31'h0, write_enable}, 32'h0);
        check({tag, "_rst_wdata"}, write_data, 32'h0);
        check({tag, "_rst_loading"}, {31'h0, loading}, 32'h1);
        check({tag, "_rst_done"}, {31'h0, done}, 32'h0);
        check({tag, "_rst_error"}, {31'h0, error}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic ld, input logic dn, input logic er);
        repeat (6) @(negedge clk);
        check({tag, "_loading"}, {31'h0, loading}, {31'h0, ld});
        check({tag, "_done"}, {31'h0, done}, {31'h0, dn});
        check({tag, "_error"}, {31'h0, error}, {31'h0, er});
        check({tag, "_writes_drained"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        @(negedge clk);
        do_reset("init");

        // Two-word program image.
        send_word(32'h0000_0002);
        check("load_hdr_loading", {31'h0, loading}, 32'h1);
        check("load_hdr_done", {31'h0, done}, 32'h0);
        expect_write(32'h0, 32'h0010_0513);
        expect_write(32'h4, 32'h0020_0593);
        send_word(32'h0010_0513);
        send_word(32'h0020_0593);
        send_csum(8'hB0);
        check_status("load", 1'b0, 1'b1, 1'b0);

        // Zero length finishes at once; later bytes are ignored.
        do_reset("zero");
        send_word(32'h0000_0000);
        check_status("zero", 1'b0, 1'b1, 1'b0);
        send_word(32'h1122_3344);
        check_status("zero_after", 1'b0, 1'b1, 1'b0);

        // Largest legal length is accepted and keeps loading.
        do_reset("max");
        send_word(32'h0000_0400);
        check_status("max_hdr", 1'b1, 1'b0, 1'b0);

        // One word past the memory size aborts without writes.
        do_reset("over");
        send_word(32'h0000_0401);
        send_word(32'hDEAD_BEEF);
        check_status("over", 1'b0, 1'b1, 1'b1);

        // Framing error on the 2nd data byte: dropped, next byte takes its slot.
        do_reset("frame");
        send_word(32'h0000_0001);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        check("frame_err_sticky", {31'h0, error}, 32'h1);
        check("frame_still_loading", {31'h0, loading}, 32'h1);
        expect_write(32'h0, 32'h5544_3311);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_csum(8'h33);
        check_status("frame", 1'b0, 1'b1, 1'b1);

        // A one-cycle low glitch while idle produces no byte.
        do_reset("glitch");
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_error", {31'h0, error}, 32'h0);
        expect_write(32'h0, 32'hDDCC_BBAA);
        send_word(32'h0000_0001);
        send_word(32'hDDCC_BBAA);
        send_csum(8'h00);
        check_status("glitch", 1'b0, 1'b1, 1'b0);

        // Reset after two data bytes, then a fresh one-word image.
        do_reset("mid");
        send_word(32'h0000_0001);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        do_reset("mid_abort");
        expect_write(32'h0, 32'h1234_5678);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        send_csum(8'h08);
        check_status("mid", 1'b0, 1'b1, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
        do_reset("csum_ok");
        expect_write(32'h0, 32'hEFBE_ADDE);
        send_word(32'h0000_0001);
        send_word(32'hEFBE_ADDE);
        check("csum_ok_pending", {31'h0, done}, 32'h0);
        send_byte(8'h22, 1'b1);
        check_status("csum_ok", 1'b0, 1'b1, 1'b0);

        do_reset("csum_bad");
        expect_write(32'h0, 32'hEFBE_ADDE);
        send_word(32'h0000_0001);
        send_word(32'hEFBE_ADDE);
        send_byte(8'h23, 1'b1);
        check_status("csum_bad", 1'b0, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
